// File: rtl/risc16_pkg.sv
// Shared definitions for the RiSC-16 core: word width, instruction field
// positions, opcode encodings and the 7-bit immediate sign extension.
package risc16_pkg;

    localparam int WORD_W  = 16;
    localparam int REG_CNT = 8;

    // Instruction field bit positions
    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 13;
    localparam int RA_HI   = 12;
    localparam int RA_LO   = 10;
    localparam int RB_HI   = 9;
    localparam int RB_LO   = 7;
    localparam int RC_HI   = 2;
    localparam int RC_LO   = 0;
    localparam int IMM7_HI = 6;
    localparam int IMM10_HI = 9;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_NAND = 3'b010,
        OP_LUI  = 3'b011,
        OP_SW   = 3'b100,
        OP_LW   = 3'b101,
        OP_BEQ  = 3'b110,
        OP_JALR = 3'b111
    } opcode_e;

    // Two's-complement extension of the 7-bit immediate to a full word
    function automatic word_t sext7(input logic [IMM7_HI:0] imm);
        return {{(WORD_W-IMM7_HI-1){imm[IMM7_HI]}}, imm};
    endfunction

endpackage

// File: rtl/risc16_regfile.sv
// Eight 16-bit registers, r0 reads as zero and ignores writes.
// Two combinational read ports, one write port committed at the clock edge.
module risc16_regfile
    import risc16_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_rd_addr1,
    output word_t      o_rd_data1,
    input  logic [2:0] i_rd_addr2,
    output word_t      o_rd_data2,
    input  logic       i_we,
    input  logic [2:0] i_wr_addr,
    input  word_t      i_wr_data
);

    word_t w_regs [REG_CNT];

    // r0 is a constant; it has no storage at all
    assign w_regs[0] = '0;

    generate
        for (genvar gi = 1; gi < REG_CNT; gi++) begin : g_reg
            word_t r_q;

            // Per-register storage, cleared asynchronously while reset is low
            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) begin
                    r_q <= '0;
                end else if (i_we && (i_wr_addr == 3'(gi))) begin
                    r_q <= i_wr_data;
                end
            end

            assign w_regs[gi] = r_q;
        end
    endgenerate

    assign o_rd_data1 = w_regs[i_rd_addr1];
    assign o_rd_data2 = w_regs[i_rd_addr2];

endmodule

// File: rtl/risc16_core.sv
// Single-cycle RiSC-16 core: fetches i_inst at o_pc and retires it on the
// next rising edge. Data memory, ALU and next-PC selection live here.
module risc16_core
    import risc16_pkg::*;
#(
    parameter int p_DATA_MEM_SIZE = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_inst,
    output logic [15:0] o_pc
);

    localparam int ADDR_W = $clog2(p_DATA_MEM_SIZE);

    word_t   r_pc;
    word_t   r_dmem [p_DATA_MEM_SIZE];

    opcode_e           w_opc;
    logic [2:0]        w_ra;
    logic [2:0]        w_rb;
    logic [2:0]        w_rc;
    logic [2:0]        w_rd2_sel;
    word_t             w_imm7;
    word_t             w_imm_lui;
    word_t             w_rd_b;
    word_t             w_rd_2;
    word_t             w_pc_inc;
    word_t             w_ea;
    logic [ADDR_W-1:0] w_addr;
    word_t             w_mem_rdata;
    logic              w_reg_we;
    word_t             w_reg_wdata;
    logic              w_mem_we;
    word_t             w_pc_next;

    assign w_opc     = opcode_e'(i_inst[OPC_HI:OPC_LO]);
    assign w_ra      = i_inst[RA_HI:RA_LO];
    assign w_rb      = i_inst[RB_HI:RB_LO];
    assign w_rc      = i_inst[RC_HI:RC_LO];
    assign w_imm7    = sext7(i_inst[IMM7_HI:0]);
    assign w_imm_lui = {i_inst[IMM10_HI:0], 6'b0};

    // Second read port serves rC for the register-register ops, rA otherwise
    // (store data and the BEQ comparand).
    assign w_rd2_sel = ((w_opc == OP_ADD) || (w_opc == OP_NAND)) ? w_rc : w_ra;

    risc16_regfile u_regfile (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rd_addr1 (w_rb),
        .o_rd_data1 (w_rd_b),
        .i_rd_addr2 (w_rd2_sel),
        .o_rd_data2 (w_rd_2),
        .i_we       (w_reg_we),
        .i_wr_addr  (w_ra),
        .i_wr_data  (w_reg_wdata)
    );

    assign w_pc_inc    = r_pc + 16'd1;
    assign w_ea        = w_rd_b + w_imm7;
    assign w_addr      = w_ea[ADDR_W-1:0];
    assign w_mem_rdata = r_dmem[w_addr];

    // Decode/execute: register write-back value, memory write enable, next PC
    always_comb begin
        w_reg_we    = 1'b0;
        w_reg_wdata = '0;
        w_mem_we    = 1'b0;
        w_pc_next   = w_pc_inc;
        case (w_opc)
            OP_ADD:  begin w_reg_we = 1'b1; w_reg_wdata = w_rd_b + w_rd_2;    end
            OP_ADDI: begin w_reg_we = 1'b1; w_reg_wdata = w_rd_b + w_imm7;    end
            OP_NAND: begin w_reg_we = 1'b1; w_reg_wdata = ~(w_rd_b & w_rd_2); end
            OP_LUI:  begin w_reg_we = 1'b1; w_reg_wdata = w_imm_lui;          end
            OP_SW:   begin w_mem_we = 1'b1;                                   end
            OP_LW:   begin w_reg_we = 1'b1; w_reg_wdata = w_mem_rdata;        end
            OP_BEQ:  begin
                if (w_rd_2 == w_rd_b) begin
                    w_pc_next = w_pc_inc + w_imm7;
                end
            end
            OP_JALR: begin
                // Link value and target both come from the pre-edge state,
                // so JALR rX,rX jumps to the old rX.
                w_reg_we    = 1'b1;
                w_reg_wdata = w_pc_inc;
                w_pc_next   = w_rd_b;
            end
            default: ;
        endcase
    end

    // Program counter, forced to zero while reset is low
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Data memory write; an edge that lands during reset must not store
    always_ff @(posedge i_clk) begin
        if (w_mem_we && i_rst) begin
            r_dmem[w_addr] <= w_rd_2;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: tb/tb_risc16_core.sv
// Bench for risc16_core: an instruction-level interpreter runs alongside the
// core and its PC/registers are compared with the core after every edge.
// Directed programs exercise reset, ALU ops, memory aliasing, BEQ, JALR and
// asynchronous reset in the middle of a store.
module tb_risc16_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] inst;
    logic [15:0] pc;

    logic [15:0] rom [256];
    assign inst = rom[pc[7:0]];

    risc16_core #(.p_DATA_MEM_SIZE(1024)) dut (
        .i_clk  (clk),
        .i_rst  (rst_n),
        .i_inst (inst),
        .o_pc   (pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [15:0] rrr(input logic [2:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic [2:0] c);
        return {op, a, b, 4'b0000, c};
    endfunction
    function automatic logic [15:0] rri(input logic [2:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic [6:0] imm);
        return {op, a, b, imm};
    endfunction
    function automatic logic [15:0] lui(input logic [2:0] a, input logic [9:0] imm);
        return {3'b011, a, imm};
    endfunction

    // ---------------- ISA-level model ----------------
    logic [15:0] m_pc;
    logic [15:0] m_reg [8];
    logic [15:0] m_mem [1024];
    bit          m_run = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 16'h0000;
            for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
        end else if (m_run) begin
            logic [15:0] ins, va, vb, vc, s7, npc, ea, res;
            int          a, idx;
            bit          wr;
            ins = rom[m_pc[7:0]];
            a   = int'(ins[12:10]);
            va  = m_reg[ins[12:10]];
            vb  = m_reg[ins[9:7]];
            vc  = m_reg[ins[2:0]];
            s7  = {{9{ins[6]}}, ins[6:0]};
            ea  = vb + s7;
            idx = int'(ea) % 1024;
            npc = m_pc + 16'd1;
            wr  = 1'b0;
            res = 16'h0000;
            case (ins[15:13])
                3'd0: begin wr = 1'b1; res = vb + vc; end
                3'd1: begin wr = 1'b1; res = vb + s7; end
                3'd2: begin wr = 1'b1; res = ~(vb & vc); end
                3'd3: begin wr = 1'b1; res = ins[9:0] * 16'd64; end
                3'd4: m_mem[idx] = va;
                3'd5: begin wr = 1'b1; res = m_mem[idx]; end
                3'd6: if (va == vb) npc = m_pc + 16'd1 + s7;
                default: begin wr = 1'b1; res = m_pc + 16'd1; npc = vb; end
            endcase
            $display("exec pc=%h inst=%h -> next pc=%h", m_pc, ins, npc);
            if (wr && a != 0) m_reg[a] = res;
            m_pc = npc;
        end
    end

    // Every-cycle comparison of architectural state against the model
    always @(negedge clk) begin
        if (m_run && rst_n) begin
            chk("pc", pc, m_pc);
            for (int i = 0; i < 8; i++)
                chk($sformatf("r%0d", i), dut.u_regfile.w_regs[i], m_reg[i]);
        end
    end

    // ---------------- sequencing helpers ----------------
    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    // Reset across two edges, release on a falling edge
    task automatic do_reset();
        m_run = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_run = 1'b1;
    endtask

    // Advance n rising edges, return just after the following falling edge
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk_reg(input string nm, input int r, input logic [15:0] lit);
        chk({nm, "/dut"}, dut.u_regfile.w_regs[r], lit);
        chk({nm, "/model"}, m_reg[r], lit);
    endtask

    initial begin
        // ---- reset behaviour ----
        clear_rom();
        m_run = 1'b0;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pc held in reset", pc, 16'h0000);
        end
        rst_n = 1'b1;
        m_run = 1'b1;
        #1 chk("pc after release", pc, 16'h0000);
        step(1); chk("pc edge1", pc, 16'h0001);
        step(1); chk("pc edge2", pc, 16'h0002);

        // ---- ALU ----
        clear_rom();
        rom[0] = rri(3'd1, 3'd1, 3'd0, 7'd5);
        rom[1] = rri(3'd1, 3'd2, 3'd0, 7'h7D);
        rom[2] = rrr(3'd0, 3'd3, 3'd1, 3'd2);
        rom[3] = rrr(3'd2, 3'd4, 3'd1, 3'd1);
        rom[4] = lui(3'd5, 10'h3FF);
        rom[5] = rri(3'd1, 3'd0, 3'd0, 7'd7);
        do_reset();
        step(7);
        chk_reg("alu r1", 1, 16'h0005);
        chk_reg("alu r2", 2, 16'hFFFD);
        chk_reg("alu r3", 3, 16'h0002);
        chk_reg("alu r4", 4, 16'hFFFA);
        chk_reg("alu r5", 5, 16'hFFC0);
        chk_reg("alu r0", 0, 16'h0000);
        chk("alu pc", pc, 16'h0007);

        // ---- memory, incl. address aliasing ----
        clear_rom();
        rom[0] = lui(3'd1, 10'h048);
        rom[1] = rri(3'd1, 3'd1, 3'd1, 7'd52);
        rom[2] = rri(3'd4, 3'd1, 3'd0, 7'd10);
        rom[3] = rri(3'd5, 3'd2, 3'd0, 7'd10);
        rom[4] = lui(3'd3, 10'd16);
        rom[5] = rri(3'd1, 3'd4, 3'd0, 7'h79);
        rom[6] = rri(3'd4, 3'd4, 3'd3, 7'd10);
        rom[7] = rri(3'd5, 3'd5, 3'd0, 7'd10);
        do_reset();
        step(4);
        chk_reg("mem r1", 1, 16'h1234);
        chk_reg("mem lw r2", 2, 16'h1234);
        step(4);
        chk_reg("mem r3", 3, 16'h0400);
        chk_reg("mem alias r5", 5, 16'hFFF9);
        chk("mem word10/dut", dut.r_dmem[10], 16'hFFF9);
        chk("mem word10/model", m_mem[10], 16'hFFF9);

        // ---- BEQ ----
        clear_rom();
        rom[0]  = rri(3'd6, 3'd0, 3'd0, 7'd63);
        rom[64] = rri(3'd1, 3'd1, 3'd0, 7'd3);
        rom[65] = rri(3'd1, 3'd2, 3'd0, 7'd3);
        rom[66] = rri(3'd6, 3'd0, 3'd0, 7'h45);
        rom[8]  = rri(3'd6, 3'd1, 3'd2, 7'h7E);
        rom[7]  = rri(3'd1, 3'd2, 3'd0, 7'd4);
        do_reset();
        step(1); chk("beq fwd 63", pc, 16'd64);
        step(1); chk("beq seq 65", pc, 16'd65);
        step(1); chk("beq seq 66", pc, 16'd66);
        step(1); chk("beq back to 8", pc, 16'd8);
        step(1); chk("beq taken -2", pc, 16'd7);
        step(1); chk("beq seq 8", pc, 16'd8);
        step(1); chk("beq not taken", pc, 16'd9);

        // ---- JALR ----
        clear_rom();
        rom[0]  = rri(3'd1, 3'd2, 3'd0, 7'h20);
        rom[1]  = rri(3'd1, 3'd3, 3'd0, 7'h10);
        rom[4]  = rri(3'd7, 3'd1, 3'd2, 7'd0);
        rom[32] = rri(3'd6, 3'd0, 3'd0, 7'h65);
        rom[6]  = rri(3'd7, 3'd3, 3'd3, 7'd0);
        do_reset();
        step(5);
        chk("jalr pc", pc, 16'h0020);
        chk_reg("jalr r1", 1, 16'h0005);
        step(1);
        chk("jalr beq to 6", pc, 16'h0006);
        step(1);
        chk("jalr self pc", pc, 16'h0010);
        chk_reg("jalr self r3", 3, 16'h0007);

        // ---- asynchronous reset during a store ----
        clear_rom();
        rom[0] = rri(3'd1, 3'd1, 3'd0, 7'd9);
        rom[1] = rri(3'd1, 3'd2, 3'd0, 7'd20);
        rom[2] = rri(3'd4, 3'd1, 3'd2, 7'd0);
        rom[3] = rri(3'd1, 3'd1, 3'd0, 7'd11);
        rom[4] = rri(3'd4, 3'd1, 3'd2, 7'd0);
        do_reset();
        step(4);
        chk("areset pre pc", pc, 16'h0004);
        chk_reg("areset pre r1", 1, 16'h000B);
        #2;
        m_run = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("areset pc now", pc, 16'h0000);
        chk("areset r1 now", dut.u_regfile.w_regs[1], 16'h0000);
        chk("areset r2 now", dut.u_regfile.w_regs[2], 16'h0000);
        @(posedge clk);
        #1;
        chk("areset mem20/dut", dut.r_dmem[20], 16'h0009);
        chk("areset mem20/model", m_mem[20], 16'h0009);
        chk("areset pc held", pc, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        m_run = 1'b1;
        step(2);
        chk("areset restart pc", pc, 16'h0002);

        m_run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/risc16_core.md
# risc16_core

Single-cycle RiSC-16 processor core: 16-bit word-addressed datapath, eight 16-bit registers (r0 hard-wired to zero), internal data memory. Each cycle it presents a PC, receives the instruction combinationally from an external instruction ROM, and fully executes it at the next rising clock edge. It sits under the system top level, which owns the instruction memory and indexes it with `o_pc`.

## Interface
- `p_DATA_MEM_SIZE`, 1024, number of 16-bit words in internal data memory (power of two).
- `i_clk`  input  1  rising-edge clock.
- `i_rst`  input  1  asynchronous, active-low reset.
- `i_inst`  input  16  instruction at address `o_pc`, valid combinationally within the same cycle.
- `o_pc`  output  16  current program counter (word address), driven directly from the PC register.

## Operation
- Fields: opcode [15:13], rA [12:10], rB [9:7], rC [2:0], imm7 [6:0] (two's complement, sign-extended to 16), imm10 [9:0].
- 000 ADD: rA = rB + rC. 001 ADDI: rA = rB + sext(imm7). 010 NAND: rA = ~(rB & rC). 011 LUI: rA = {imm10, 6'b0}.
- 100 SW: mem[rB + sext(imm7)] = rA. 101 LW: rA = mem[rB + sext(imm7)].
- 110 BEQ: if rA == rB then PC = PC + 1 + sext(imm7), else PC + 1.
- 111 JALR: rA = PC + 1; PC = rB (value read before the write, so rA == rB is well defined). imm7 ignored.
- All other opcodes: PC = PC + 1.
- Arithmetic is modulo 2^16; no flags, no overflow detection. PC wraps FFFF -> 0000.
- Writes to r0 discarded; r0 always reads 0.
- Data memory address = effective address modulo `p_DATA_MEM_SIZE` (low log2 bits).
- Register reads and data memory reads are combinational; register write, memory write and PC update occur together at the rising edge.

## Timing
- Reset (`i_rst` low): PC = 0 and r1–r7 = 0 immediately, asynchronously; held while low. Data memory is not reset (contents undefined until written). First instruction fetched from address 0 in the first cycle after release.
- Latency: one cycle per instruction; result of instruction N is visible to instruction N+1 (no hazards, no stalls).
- `o_pc` changes only at a rising edge or on reset assertion.
- LW after SW to the same address in the next cycle returns the stored value.
- Reset asserted mid-cycle aborts the pending instruction; no register or memory write occurs on that edge.

## Structure
- Shared package: opcode constants (ADD, ADDI, NAND, LUI, SW, LW, BEQ, JALR), field bit positions, 16-bit word width.
- Sub-module `risc16_regfile`: 8x16 registers, two async read ports, one sync write port, r0 forced to zero, async active-low reset.
- Data memory, ALU, immediate extension and next-PC mux inline in the core.

## Test plan
- Reset: hold `i_rst` low across edges -> `o_pc` = 0; release -> `o_pc` 0,1,2 on successive edges with NOP-equivalent `ADD r0,r0,r0`.
- ALU: ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; NAND r4,r1,r1; LUI r5,0x3FF -> r3 = 0x0002, r4 = 0xFFFA, r5 = 0xFFC0; ADDI r0,r0,7 leaves r0 = 0.
- Memory: ADDI r1,r0,0x1234-like value via LUI+ADDI, SW r1,r0,10; LW r2,r0,10 -> r2 equals r1; SW at address 1034 then LW at 10 -> aliases (size 1024).
- BEQ: r1 == r2 with imm7 = -2 at PC 8 -> next PC 7; r1 != r2 -> next PC 9; imm7 = 63 at PC 0 taken -> PC 64.
- JALR: r2 = 0x0020, JALR r1,r2 at PC 4 -> PC 0x0020, r1 = 5; JALR r3,r3 with r3 = 0x10 at PC 6 -> PC 0x10, r3 = 7.
- Async reset mid-run: assert `i_rst` low between edges during a SW -> `o_pc` = 0 at once, registers cleared, target memory word unchanged.
